// File: rtl/icx_spi_slave.sv
// Channel-side end of the inter-FPGA 3-wire SPI link: turns 16-bit SPI words
// into Wishbone cycles and serialises read data back on the shared data line.
module icx_spi_slave #(
  parameter int ADDR_WIDTH  = 15,
  parameter int CLK_POL     = 0,
  parameter int ACK_TIMEOUT = 32
) (
  input  logic                  wb_clk,
  input  logic                  wb_rst,
  input  logic                  spi_cs,
  input  logic                  spi_clk,
  input  logic                  spi_dat_i,
  output logic                  spi_dat_o,
  output logic                  spi_dat_oe,
  output logic                  wb_cyc,
  output logic                  wb_stb,
  output logic                  wb_we,
  output logic [ADDR_WIDTH-1:0] wb_adr,
  output logic [15:0]           wb_dat_o,
  input  logic [15:0]           wb_dat_i,
  input  logic                  wb_ack,
  output logic                  timeout
);

  // state  | meaning
  // IDLE   | waiting for chip select
  // CMD    | shifting in the command word
  // WDATA  | shifting in a write data word
  // WB_WR  | write cycle on the bus
  // RD_REQ | read cycle on the bus (first fetch or prefetch)
  // RDATA  | shifting read data out to the master
  // FLUSH  | CS gone high, finishing the pending bus cycle
  typedef enum logic [2:0] {IDLE, CMD, WDATA, WB_WR, RD_REQ, RDATA, FLUSH} state_t;

  localparam int            TW       = $clog2(ACK_TIMEOUT) + 1;
  localparam logic [TW-1:0] TMR_LOAD = TW'(ACK_TIMEOUT - 1);
  localparam logic          POL      = (CLK_POL != 0);

  state_t                  state;
  logic [1:0]              cs_s;
  logic [2:0]              clk_s;
  logic [1:0]              dat_s;
  logic [3:0]              bit_cnt;
  logic [14:0]             rx;
  logic [15:0]             tx;
  logic [ADDR_WIDTH-1:0]   addr;
  logic [TW-1:0]           tmr;

  logic                    cs_low, clk_now, clk_prv, samp, shft;
  logic                    in_frame, word_done, bus_done, bus_to;
  logic [15:0]             rx_next;
  logic [ADDR_WIDTH-1:0]   cmd_adr, addr_inc;

  assign cs_low    = ~cs_s[1];
  assign clk_now   = clk_s[1] ^ POL;
  assign clk_prv   = clk_s[2] ^ POL;
  assign samp      = clk_now & ~clk_prv;
  assign shft      = ~clk_now & clk_prv;
  assign in_frame  = cs_low && (state != IDLE) && (state != FLUSH);
  assign word_done = in_frame && samp && (bit_cnt == 4'd15);
  assign rx_next   = {rx, dat_s[1]};
  assign cmd_adr   = ADDR_WIDTH'(rx_next[14:0]);
  assign addr_inc  = addr + ADDR_WIDTH'(1);
  // Ack wins over a timer expiring in the same cycle.
  assign bus_done  = wb_cyc && (wb_ack || (tmr == '0));
  assign bus_to    = wb_cyc && !wb_ack && (tmr == '0);
  assign spi_dat_o = tx[15];

  always_ff @(posedge wb_clk) begin
    if (!wb_rst) begin
      state      <= IDLE;
      cs_s       <= 2'b11;
      clk_s      <= '0;
      dat_s      <= '0;
      bit_cnt    <= '0;
      rx         <= '0;
      tx         <= '0;
      addr       <= '0;
      tmr        <= '0;
      wb_cyc     <= 1'b0;
      wb_stb     <= 1'b0;
      wb_we      <= 1'b0;
      wb_adr     <= '0;
      wb_dat_o   <= '0;
      spi_dat_oe <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      cs_s    <= {cs_s[0], spi_cs};
      clk_s   <= {clk_s[1:0], spi_clk};
      dat_s   <= {dat_s[0], spi_dat_i};
      timeout <= 1'b0;

      // Bits keep arriving even while a bus cycle is still outstanding.
      if (in_frame && samp) begin
        rx      <= rx_next[14:0];
        bit_cnt <= bit_cnt + 4'd1;
      end

      if (wb_cyc) begin
        if (bus_done) begin
          wb_cyc  <= 1'b0;
          wb_stb  <= 1'b0;
          timeout <= bus_to;
        end else begin
          tmr <= tmr - TW'(1);
        end
      end

      if (state != IDLE && state != FLUSH && !cs_low) begin
        bit_cnt    <= '0;
        spi_dat_oe <= 1'b0;
        state      <= (wb_cyc && !bus_done) ? FLUSH : IDLE;
      end else begin
        case (state)
          IDLE: begin
            bit_cnt <= '0;
            if (cs_low) state <= CMD;
          end
          CMD: begin
            if (word_done) begin
              addr <= cmd_adr;
              if (rx_next[15]) begin
                state <= WDATA;
              end else begin
                wb_adr <= cmd_adr;
                wb_we  <= 1'b0;
                wb_cyc <= 1'b1;
                wb_stb <= 1'b1;
                tmr    <= TMR_LOAD;
                state  <= RD_REQ;
              end
            end
          end
          WDATA: begin
            if (word_done) begin
              wb_dat_o <= rx_next;
              wb_adr   <= addr;
              wb_we    <= 1'b1;
              wb_cyc   <= 1'b1;
              wb_stb   <= 1'b1;
              tmr      <= TMR_LOAD;
              state    <= WB_WR;
            end
          end
          WB_WR: begin
            if (bus_done) begin
              addr  <= addr_inc;
              state <= WDATA;
            end
          end
          RD_REQ: begin
            if (bus_done) begin
              tx         <= wb_ack ? wb_dat_i : 16'hFFFF;
              spi_dat_oe <= 1'b1;
              state      <= RDATA;
            end
          end
          RDATA: begin
            // bit_cnt==0 means the trailing edge of the previous word: keep MSB.
            if (shft && bit_cnt != 4'd0) tx <= {tx[14:0], 1'b0};
            if (word_done) begin
              addr       <= addr_inc;
              wb_adr     <= addr_inc;
              wb_we      <= 1'b0;
              wb_cyc     <= 1'b1;
              wb_stb     <= 1'b1;
              tmr        <= TMR_LOAD;
              spi_dat_oe <= 1'b0;
              state      <= RD_REQ;
            end
          end
          FLUSH: begin
            if (!wb_cyc || bus_done) state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_icx_spi_slave.sv
// Scoreboard bench for icx_spi_slave: an SPI master task, a Wishbone slave
// model and a frame-level reference model that predicts bus cycles and read data.
module tb_icx_spi_slave;
  localparam int H   = 28;
  localparam int GAP = 80;
  localparam int TO  = 32;

  typedef struct packed {
    logic        we;
    logic [14:0] adr;
    logic [15:0] dat;
  } bus_t;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b0;
  logic        spi_cs = 1'b1;
  logic        spi_clk = 1'b0;
  logic        spi_dat_i = 1'b0;
  logic        spi_dat_o, spi_dat_oe;
  logic        wb_cyc, wb_stb, wb_we, timeout;
  logic [14:0] wb_adr;
  logic [15:0] wb_dat_o;
  logic [15:0] wb_dat_i = 16'h0;
  logic        wb_ack = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;
  int to_seen = 0;
  int to_exp = 0;
  int noack_adr = -1;

  bus_t        exp_bus[$];
  logic [15:0] exp_rx[$];
  logic [15:0] act_rx[$];
  logic [15:0] mmem[int];
  logic [15:0] smem[int];

  icx_spi_slave #(.ADDR_WIDTH(15), .CLK_POL(0), .ACK_TIMEOUT(TO)) dut (
    .wb_clk(wb_clk), .wb_rst(wb_rst), .spi_cs(spi_cs), .spi_clk(spi_clk),
    .spi_dat_i(spi_dat_i), .spi_dat_o(spi_dat_o), .spi_dat_oe(spi_dat_oe),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack), .timeout(timeout)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] mrd(input int a);
    return mmem.exists(a) ? mmem[a] : 16'h0;
  endfunction

  // Reference model: a write frame writes consecutive addresses; a read frame
  // reads n consecutive words plus one prefetch; unacked reads return FFFF.
  task automatic model_write(input int a0, input logic [15:0] d[$]);
    bus_t e;
    for (int i = 0; i < d.size(); i++) begin
      e.we = 1'b1; e.adr = 15'((a0 + i) % 32768); e.dat = d[i];
      exp_bus.push_back(e);
      mmem[(a0 + i) % 32768] = d[i];
    end
  endtask

  task automatic model_read(input int a0, input int n);
    bus_t e;
    int   a;
    for (int i = 0; i <= n; i++) begin
      a = (a0 + i) % 32768;
      e.we = 1'b0; e.adr = 15'(a); e.dat = 16'h0;
      exp_bus.push_back(e);
      if (a == noack_adr) to_exp++;
      if (i < n) exp_rx.push_back(a == noack_adr ? 16'hFFFF : mrd(a));
    end
  endtask

  // Wishbone slave (ack after 2 cycles) plus bus-cycle and timeout monitor.
  initial begin
    bit   in_cyc = 0;
    int   cnt = 0, cyc_count = 0, stb_t = 0;
    bus_t e;
    forever begin
      @(negedge wb_clk);
      cyc_count++;
      if (timeout) begin
        to_seen++;
        chk("timeout_latency", 32'(cyc_count - stb_t), 32'(TO));
      end
      if (wb_cyc && wb_stb) begin
        if (!in_cyc) begin
          in_cyc = 1; cnt = 0; stb_t = cyc_count;
          if (exp_bus.size() == 0) begin
            n_cmp++; n_bad++;
            $display("FAIL unexpected_bus: we=%0b adr=0x%0h dat=0x%0h", wb_we, wb_adr, wb_dat_o);
          end else begin
            e = exp_bus.pop_front();
            chk("bus_we", 32'(wb_we), 32'(e.we));
            chk("bus_adr", 32'(wb_adr), 32'(e.adr));
            if (e.we) chk("bus_wdat", 32'(wb_dat_o), 32'(e.dat));
          end
        end
        if (!wb_ack) begin
          cnt++;
          if (cnt >= 2 && int'(wb_adr) != noack_adr) begin
            wb_ack = 1'b1;
            if (wb_we) smem[int'(wb_adr)] = wb_dat_o;
            else wb_dat_i = smem.exists(int'(wb_adr)) ? smem[int'(wb_adr)] : 16'h0;
          end
        end
      end else begin
        in_cyc = 0;
        wb_ack = 1'b0;
      end
    end
  end

  // Read-data monitor: compares words the master shifted in.
  initial begin
    logic [15:0] a;
    forever begin
      @(negedge wb_clk);
      while (act_rx.size() > 0) begin
        a = act_rx.pop_front();
        if (exp_rx.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL unexpected_rx: got 0x%0h", a);
        end else begin
          chk("rx_word", 32'(a), 32'(exp_rx.pop_front()));
        end
      end
    end
  end

  task automatic spi_word(input logic [15:0] w, input int nbits, input bit exp_oe,
                          output logic [15:0] got);
    got = 16'h0;
    for (int i = 0; i < nbits; i++) begin
      spi_dat_i = w[15-i];
      repeat (H) @(negedge wb_clk);
      if (i == 0) chk("oe_at_word_start", 32'(spi_dat_oe), 32'(exp_oe));
      got = {got[14:0], spi_dat_o};
      spi_clk = 1'b1;
      repeat (H) @(negedge wb_clk);
      spi_clk = 1'b0;
    end
  endtask

  task automatic frame_end();
    repeat (H) @(negedge wb_clk);
    spi_cs = 1'b1;
    spi_dat_i = 1'b0;
    repeat (GAP) @(negedge wb_clk);
  endtask

  task automatic wr_frame(input int a0, input logic [15:0] d[$]);
    logic [15:0] g;
    model_write(a0, d);
    spi_cs = 1'b0;
    spi_word({1'b1, 15'(a0)}, 16, 1'b0, g);
    foreach (d[i]) spi_word(d[i], 16, 1'b0, g);
    frame_end();
  endtask

  task automatic rd_frame(input int a0, input int n);
    logic [15:0] g;
    model_read(a0, n);
    spi_cs = 1'b0;
    spi_word({1'b0, 15'(a0)}, 16, 1'b0, g);
    for (int i = 0; i < n; i++) begin
      spi_word(16'h0, 16, 1'b1, g);
      act_rx.push_back(g);
    end
    frame_end();
  endtask

  initial begin
    logic [15:0] g;
    logic [15:0] d[$];
    int          a, n;

    repeat (3) @(negedge wb_clk);
    chk("rst_cyc", 32'(wb_cyc), 0);
    chk("rst_stb", 32'(wb_stb), 0);
    chk("rst_we", 32'(wb_we), 0);
    chk("rst_adr", 32'(wb_adr), 0);
    chk("rst_wdat", 32'(wb_dat_o), 0);
    chk("rst_oe", 32'(spi_dat_oe), 0);
    chk("rst_dout", 32'(spi_dat_o), 0);
    chk("rst_timeout", 32'(timeout), 0);
    wb_rst = 1'b1;
    repeat (10) @(negedge wb_clk);

    wr_frame(5, '{16'h1234, 16'hABCD});

    mmem[16'h10] = 16'h5A5A; smem[16'h10] = 16'h5A5A;
    mmem[16'h11] = 16'hC3C3; smem[16'h11] = 16'hC3C3;
    rd_frame(16'h10, 2);

    wr_frame(16'h7FFF, '{16'h0001, 16'h0002});

    mmem[16'h21] = 16'h2121; smem[16'h21] = 16'h2121;
    noack_adr = 16'h20;
    rd_frame(16'h20, 2);
    noack_adr = -1;

    // CS abort after 7 bits of the second data word.
    model_write(3, '{16'h1111});
    spi_cs = 1'b0;
    spi_word(16'h8003, 16, 1'b0, g);
    spi_word(16'h1111, 16, 1'b0, g);
    spi_word(16'h2222, 7, 1'b0, g);
    frame_end();
    wr_frame(1, '{16'h00EE});
    rd_frame(1, 1);

    // Reset while a write cycle is held open.
    noack_adr = 16'h40;
    begin
      bus_t e;
      e.we = 1'b1; e.adr = 15'h40; e.dat = 16'h7777;
      exp_bus.push_back(e);
    end
    spi_cs = 1'b0;
    spi_word(16'h8040, 16, 1'b0, g);
    spi_word(16'h7777, 16, 1'b0, g);
    for (int i = 0; i < 100 && !wb_cyc; i++) @(negedge wb_clk);
    chk("midcyc_cyc_seen", 32'(wb_cyc), 1);
    repeat (3) @(negedge wb_clk);
    wb_rst = 1'b0;
    @(negedge wb_clk);
    chk("midrst_cyc", 32'(wb_cyc), 0);
    chk("midrst_stb", 32'(wb_stb), 0);
    chk("midrst_oe", 32'(spi_dat_oe), 0);
    chk("midrst_timeout", 32'(timeout), 0);
    wb_rst = 1'b1;
    spi_cs = 1'b1;
    spi_dat_i = 1'b0;
    repeat (GAP) @(negedge wb_clk);
    noack_adr = -1;
    wr_frame(16'h41, '{16'h4141});
    rd_frame(16'h40, 2);

    for (int k = 0; k < 5; k++) begin
      a = $urandom_range(0, 32767);
      n = $urandom_range(1, 3);
      d.delete();
      for (int i = 0; i < n; i++) d.push_back(16'($urandom));
      wr_frame(a, d);
      rd_frame(a, n);
    end

    repeat (200) @(negedge wb_clk);
    chk("bus_queue_drained", 32'(exp_bus.size()), 0);
    chk("rx_queue_drained", 32'(exp_rx.size()), 0);
    chk("timeout_count", 32'(to_seen), 32'(to_exp));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/icx_spi_slave.md
Name: icx_spi_slave

Overview:
- Channel-FPGA end of the inter-FPGA SPI link driven by the main FPGA's xspi_master over ICX[2] (CS), ICX[3] (data) and ICX[4] (clock).
- Deserialises 16-bit SPI words into Wishbone master cycles on the channel FPGA's local bus; read data is serialised back over the same 3-wire data line.
- Runs entirely in wb_clk; SPI lines are asynchronous and are oversampled.

Parameters:
- ADDR_WIDTH, 15, width of wb_adr; word address taken from command bits [14:0], zero-extended or truncated to fit.
- CLK_POL, 0, SPI clock idle level; 0 = sample on rising edge, shift out on falling edge; 1 = inverted.
- ACK_TIMEOUT, 32, wb_clk cycles to wait for wb_ack before abandoning a cycle.

Ports:
- wb_clk  in  1  single clock for all logic
- wb_rst  in  1  synchronous reset, active-low
- spi_cs  in  1  chip select, active-low, asynchronous
- spi_clk  in  1  SPI clock, asynchronous, at most wb_clk/8
- spi_dat_i  in  1  SPI data from master
- spi_dat_o  out  1  SPI data to master
- spi_dat_oe  out  1  1 = drive spi_dat_o onto the shared line
- wb_cyc  out  1  Wishbone cycle
- wb_stb  out  1  Wishbone strobe
- wb_we  out  1  Wishbone write enable
- wb_adr  out  ADDR_WIDTH  Wishbone word address
- wb_dat_o  out  16  write data
- wb_dat_i  in  16  read data
- wb_ack  in  1  Wishbone acknowledge
- timeout  out  1  one-cycle pulse when a cycle is abandoned

Behaviour:
- Reset (wb_rst=0 at a wb_clk edge): all outputs 0, state IDLE, shift registers 0. Reset mid-frame or mid-cycle drops wb_cyc/wb_stb on the next edge with no completion.
- Synchronisation: spi_cs, spi_clk and spi_dat_i each pass through 2 flip-flops. Edge detect uses a 3rd stage. Sample/shift events are single-cycle pulses 3 cycles after the pin edge.
- Framing: all words are 16 bits, MSB first.
  - First word after CS falls is the command: bit15 = 1 write, 0 read; bits[14:0] = start address.
  - Each following word is one data word. The address auto-increments by 1 after every completed bus cycle and wraps modulo 2^ADDR_WIDTH.
- States: IDLE, CMD, WDATA, WB_WR, RD_REQ, RDATA, FLUSH.
  - IDLE: waits for synced CS low, clears bit counter, goes to CMD.
  - CMD: shifts 16 bits. On the 16th sample, latches the address. Goes to WDATA if write, RD_REQ if read.
  - WDATA: shifts 16 bits. On the 16th sample, wb_dat_o <= word, wb_adr <= address, wb_we=1, cyc=stb=1; go to WB_WR.
  - WB_WR: holds cyc/stb until wb_ack or timeout. Deasserts on the cycle after ack, increments the address, returns to WDATA.
  - RD_REQ: issues a read (we=0). On ack, loads wb_dat_i into the tx shift register and goes to RDATA. The first data bit is driven before the first shift edge of the next word.
  - RDATA: spi_dat_oe=1; spi_dat_o = tx MSB, shifted on each shift edge. After the 16th shift-clock period, increment the address and go to RD_REQ (prefetch of the next word).
  - Prefetch side effect: one extra read beyond the last word consumed is issued. FIFO-type targets must be read one word per frame.
- Timeout: cyc/stb held ACK_TIMEOUT cycles without ack -> drop cyc/stb, pulse timeout for 1 cycle. Read data becomes 16'hFFFF; writes are lost. The state machine continues as if acked.
- CS deassertion:
  - Any state with CS high and no bus cycle pending -> IDLE; partial word discarded.
  - Bus cycle pending -> FLUSH: complete on ack or timeout, then IDLE.
  - spi_dat_oe drops within 3 cycles of the CS pin rising.
- spi_dat_oe=0 in IDLE, CMD, WDATA, WB_WR, FLUSH.
- CS falling while in FLUSH is ignored until IDLE is reached; the master guarantees a CS-high gap of at least ACK_TIMEOUT+8 cycles.
- Simultaneous ack and timeout expiry in the same cycle: treated as ack.
- Clocks arriving after the 16th bit of a word with no bus completion yet: bits for the next word are still shifted in. Bus latency must stay below 16 SPI half-periods.

Test Plan:
- Write frame: command 16'h8005, data 16'h1234, 16'hABCD, slave acks after 2 cycles -> writes 0x1234@5 and 0xABCD@6; timeout never pulses.
- Read frame: command 16'h0010, then 2 words; model returns 0x5A5A@0x10 and 0xC3C3@0x11 -> master shifts in 0x5A5A, then 0xC3C3; a third prefetch read occurs at 0x12; oe high only during data words.
- Wrap: write command 16'hFFFF, data words 0x0001 and 0x0002 -> writes at 0x7FFF, then at 0x0000.
- Timeout: read @0x20, slave never acks -> timeout pulses once 32 cycles after stb; master receives 0xFFFF; next read proceeds at 0x21.
- CS abort: CS rises after 7 bits of a data word in a write frame -> no bus cycle; IDLE; a new frame 16'h8001/0x00EE writes 0xEE@1.
- Reset mid-cycle: wb_rst=0 while cyc=1 -> cyc, stb, oe and timeout all 0 on the next edge; the next frame works normally.
